// File: rtl/sos_request_sequencer.sv
// Queues N requests, issues them one at a time to the sum-of-squares block and returns {N, sum}; N=0 is answered locally.
// Latency: push to N_valid 2 cycles, sum_valid to res_valid/ack 1 cycle. Backpressure: req_ready=!full; FSM holds in IDLE while the result is unaccepted.
// Optional checker enabled by SOS_CHECK_EN: compares sum_out with N(N+1)(2N+1)/6 and flags res_err.
module sos_request_sequencer #(
    parameter int DEPTH   = 4,
    parameter int N_W     = 3,
    parameter int SUM_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_W-1:0]   req_n,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [N_W-1:0]   N,
    output logic             N_valid,
    input  logic [SUM_W-1:0] sum_out,
    input  logic             sum_valid,
    output logic             ack,
    output logic [N_W-1:0]   res_n,
    output logic [SUM_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_timeout,
    output logic             res_err,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t         state;
    logic [N_W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [TW-1:0]  wd_cnt;
    logic [N_W-1:0] head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           head_zero;
    logic           res_free;
    logic           accept;
    logic           capture;
    logic           wd_expire;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head      = mem[rd_ptr];
    assign head_zero = (head == '0);
    assign accept    = res_valid && res_ready;
    assign res_free  = !res_valid || res_ready;
    // A still-asserted sum_valid blocks issue so a stale answer is never paired with the next N.
    assign pop       = (state == IDLE) && !empty && res_free && (head_zero || !sum_valid);
    assign capture   = (state == WAIT) && sum_valid;
    assign wd_expire = (state == WAIT) && !sum_valid && (wd_cnt == TW'(TIMEOUT-1));
    assign busy      = !empty || (state != IDLE);

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= req_n;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            N           <= '0;
            N_valid     <= 1'b0;
            ack         <= 1'b0;
            wd_cnt      <= '0;
            res_valid   <= 1'b0;
            res_n       <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
        end else begin
            N_valid <= 1'b0;
            ack     <= 1'b0;
            if (accept) begin
                res_valid   <= 1'b0;
                res_n       <= '0;
                res_data    <= '0;
                res_timeout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_zero) begin
                            res_valid   <= 1'b1;
                            res_n       <= '0;
                            res_data    <= '0;
                            res_timeout <= 1'b0;
                        end else begin
                            N       <= head;
                            N_valid <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (sum_valid) begin
                        res_valid   <= 1'b1;
                        res_n       <= N;
                        res_data    <= sum_out;
                        res_timeout <= 1'b0;
                        ack         <= 1'b1;
                        state       <= ACK;
                    end else if (wd_expire) begin
                        // Dead compute block: report a zero result flagged as timed out, no ack.
                        res_valid   <= 1'b1;
                        res_n       <= N;
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SOS_CHECK_EN
    localparam int CW = 3*N_W + 2;

    logic [CW-1:0] n_ext;
    logic [CW-1:0] sos_ref;
    logic          chk_mismatch;

    assign n_ext        = CW'(N);
    assign sos_ref      = (n_ext * (n_ext + CW'(1)) * ((n_ext << 1) + CW'(1))) / CW'(6);
    assign chk_mismatch = ({{CW{1'b0}}, sum_out} != {{SUM_W{1'b0}}, sos_ref});

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            res_err <= 1'b0;
        end else if (capture) begin
            res_err <= chk_mismatch;
        end else if (accept || wd_expire || (pop && head_zero)) begin
            res_err <= 1'b0;
        end
    end
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_sos_request_sequencer.sv
// Directed and randomized bench for sos_request_sequencer with a behavioural compute-block model and result scoreboard.
module tb_sos_request_sequencer;
    localparam int DEPTH   = 4;
    localparam int N_W     = 3;
    localparam int SUM_W   = 8;
    localparam int TIMEOUT = 64;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [N_W-1:0]   req_n;
    logic             req_valid;
    logic             req_ready;
    logic [N_W-1:0]   N;
    logic             N_valid;
    logic [SUM_W-1:0] sum_out;
    logic             sum_valid;
    logic             ack;
    logic [N_W-1:0]   res_n;
    logic [SUM_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;
    logic             res_timeout;
    logic             res_err;
    logic             busy;

    sos_request_sequencer #(.DEPTH(DEPTH), .N_W(N_W), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst), .req_n(req_n), .req_valid(req_valid), .req_ready(req_ready),
        .N(N), .N_valid(N_valid), .sum_out(sum_out), .sum_valid(sum_valid), .ack(ack),
        .res_n(res_n), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_timeout(res_timeout), .res_err(res_err), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int lat_cfg = 1;
    bit dead = 1'b0;
    bit corrupt = 1'b0;
    bit rnd_rdy = 1'b0;
    int ack_cnt = 0;
    int nvalid_cnt = 0;
    logic prev_nvalid = 1'b0;
    logic prev_ack = 1'b0;
    logic [N_W-1:0] push_q[$];
    logic [N_W-1:0] issue_q[$];

    function automatic int sos(input int n);
        int s = 0;
        for (int i = 1; i <= n; i++) s += i * i;
        return s;
    endfunction

    function automatic logic [20:0] outs();
        return {req_ready, N, N_valid, ack, res_n, res_data, res_valid, res_timeout, res_err, busy};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compute-block model: answers lat_cfg cycles after the strobe, holds sum_valid until ack.
    logic pend;
    int cnt;
    logic [N_W-1:0] n_l;
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sum_valid <= 1'b0;
            sum_out   <= '0;
            pend      <= 1'b0;
            cnt       <= 0;
            n_l       <= '0;
        end else begin
            if (N_valid && !dead) begin
                pend <= 1'b1;
                cnt  <= lat_cfg;
                n_l  <= N;
            end else if (pend) begin
                if (cnt == 0) begin
                    sum_valid <= 1'b1;
                    sum_out   <= SUM_W'(sos(int'(n_l)) + (corrupt ? 1 : 0));
                    pend      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (ack) sum_valid <= 1'b0;
        end
    end

    task automatic check_result();
        logic [N_W-1:0] n;
        int  e_data;
        bit  e_to;
        bit  e_err;
        chk("result_expected", push_q.size() > 0, 1);
        if (push_q.size() == 0) return;
        n = push_q.pop_front();
        e_to   = (n != 0) && dead;
        e_data = (n == 0 || dead) ? 0 : sos(int'(n)) + (corrupt ? 1 : 0);
`ifdef SOS_CHECK_EN
        e_err  = (n != 0) && !dead && corrupt;
`else
        e_err  = 1'b0;
`endif
        chk("res_n", res_n, n);
        chk("res_data", res_data, e_data);
        chk("res_timeout", res_timeout, e_to);
        chk("res_err", res_err, e_err);
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            if (req_valid && req_ready) begin
                push_q.push_back(req_n);
                if (req_n != 0) issue_q.push_back(req_n);
            end
            if (N_valid) begin
                nvalid_cnt++;
                chk("nvalid_one_cycle", prev_nvalid, 0);
                chk("issue_expected", issue_q.size() > 0, 1);
                if (issue_q.size() > 0) chk("issue_n", N, issue_q.pop_front());
            end
            if (ack) begin
                ack_cnt++;
                chk("ack_one_cycle", prev_ack, 0);
            end
            if (res_valid && res_ready) check_result();
        end
        prev_nvalid = N_valid;
        prev_ack    = ack;
    end

    task automatic push(input logic [N_W-1:0] n);
        int t = 0;
        req_n     = n;
        req_valid = 1'b1;
        forever begin
            if (rnd_rdy) res_ready = ($urandom_range(0, 3) != 0);
            @(negedge Clk);
            if (req_ready || t > 500) break;
            t++;
            @(posedge Clk); #1;
        end
        chk("push_accepted", req_ready, 1);
        @(posedge Clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        res_ready = 1'b1;
        forever begin
            @(negedge Clk);
            if ((push_q.size() == 0 && !busy && !res_valid && !sum_valid) || t > 3000) break;
            t++;
        end
        chk("drain_done", push_q.size() == 0 && !busy && !res_valid, 1);
        @(posedge Clk); #1;
    endtask

    task automatic step_until_nvalid();
        int t = 0;
        while (!N_valid && t < 20) begin
            @(posedge Clk); #1;
            t++;
        end
        chk("nvalid_seen", N_valid, 1);
    endtask

    initial begin
        int cyc;
        int a0;
        int n0;
        req_n = '0;
        req_valid = 1'b0;
        res_ready = 1'b0;

        #2 Rst = 1'b0;
        #1 chk("reset_outputs", outs(), 21'h100000);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;

        // Single request, slow result held until accepted
        lat_cfg = 5;
        a0 = ack_cnt;
        push(3'd4);
        chk("t1_no_early_issue", N_valid, 0);
        @(posedge Clk); #1;
        chk("t1_nvalid", N_valid, 1);
        chk("t1_n", N, 4);
        @(posedge Clk); #1;
        chk("t1_nvalid_drop", N_valid, 0);
        cyc = 1;
        while (!res_valid && cyc < 200) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk("t1_latency", cyc, 5 + 3);
        chk("t1_ack_with_result", ack, 1);
        chk("t1_res_n", res_n, 4);
        chk("t1_res_data", res_data, 30);
        @(posedge Clk); #1;
        chk("t1_ack_drop", ack, 0);
        repeat (3) @(posedge Clk);
        #1 chk("t1_res_held", res_valid, 1);
        res_ready = 1'b1;
        @(posedge Clk); #1;
        chk("t1_res_clear", res_valid, 0);
        chk("t1_ack_count", ack_cnt - a0, 1);
        drain();

        // Back-to-back including a locally answered N=0
        lat_cfg = 1;
        n0 = nvalid_cnt;
        push(3'd3);
        push(3'd7);
        push(3'd0);
        push(3'd1);
        drain();
        chk("t2_issue_count", nvalid_cnt - n0, 3);

        // Result stall fills the FIFO
        lat_cfg = 2;
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(N_W'(i));
        repeat (6) @(posedge Clk);
        #1;
        chk("t3_req_ready_full", req_ready, 0);
        chk("t3_res_stalled", res_valid, 1);
        chk("t3_res_first", res_n, 1);
        chk("t3_busy", busy, 1);
        res_ready = 1'b1;
        push(3'd6);
        drain();

        // Watchdog abort, then normal service
        res_ready = 1'b1;
        dead = 1'b1;
        a0 = ack_cnt;
        push(3'd5);
        step_until_nvalid();
        cyc = 0;
        while (!res_valid && cyc < TIMEOUT + 20) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk("t4_timeout_latency", cyc, TIMEOUT + 1);
        chk("t4_timeout_flag", res_timeout, 1);
        chk("t4_timeout_data", res_data, 0);
        drain();
        chk("t4_no_ack", ack_cnt - a0, 0);
        dead = 1'b0;
        push(3'd2);
        drain();

        // Wrong answer from the compute block
        corrupt = 1'b1;
        push(3'd4);
        drain();
        corrupt = 1'b0;

        // Reset while waiting on the compute block
        lat_cfg = 20;
        push(3'd6);
        step_until_nvalid();
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        #1 chk("t6_reset_outputs", outs(), 21'h100000);
        push_q.delete();
        issue_q.delete();
        @(negedge Clk);
        Rst = 1'b1;
        lat_cfg = 1;
        a0 = ack_cnt;
        @(posedge Clk); #1;
        push(3'd2);
        drain();
        chk("t6_ack_after_reset", ack_cnt - a0, 1);

        // Randomized traffic with random downstream backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            lat_cfg = $urandom_range(0, 4);
            push(N_W'($urandom_range(0, 7)));
        end
        rnd_rdy = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sos_request_sequencer.md
# sos_request_sequencer

Upstream stage of the sum-of-squares datapath. Queues incoming N requests, issues them one at a time to the sum-of-squares compute block over its N/N_valid interface, waits for sum_valid, and acknowledges with ack. Captured results are returned with their N on a ready/valid result port. N=0 is answered locally, and a watchdog prevents a dead compute block from hanging the sequencer.

## Interface
Parameters:
- DEPTH, 4: request FIFO depth; power of two, ≥2
- N_W, 3: width of N
- SUM_W, 8: width of sum_out/res_data
- TIMEOUT, 64: max cycles spent in WAIT before abort; ≥2

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Rst  in  1  reset, asynchronous, active-low
- req_n  in  N_W  requested N
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- N  out  N_W  N to compute block
- N_valid  out  1  one-cycle issue strobe to compute block
- sum_out  in  SUM_W  result from compute block
- sum_valid  in  1  result valid; held by compute block until ack
- ack  out  1  one-cycle result acknowledge
- res_n  out  N_W  N belonging to res_data
- res_data  out  SUM_W  sum of squares 1..N
- res_valid  out  1  result held until accepted
- res_ready  in  1  downstream accepts
- res_timeout  out  1  qualifies res_valid: entry aborted by watchdog
- res_err  out  1  qualifies res_valid: checker mismatch (see Configuration)
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO push on req_valid && req_ready; req_ready = !full (combinational, no pass-through when full).
- Result register: single entry; res_valid, res_n, res_data, res_timeout and res_err are all registered. Cleared on res_valid && res_ready.
- FSM states IDLE, ISSUE, WAIT, ACK.
- IDLE → ISSUE: FIFO non-empty, sum_valid low, and result register empty or being emptied this cycle. Pop head into N.
- IDLE, head N=0: pop and load result directly (res_data=0). The compute block is not engaged. Stay in IDLE.
- ISSUE: N_valid=1 for exactly one cycle, then → WAIT. Watchdog counter cleared.
- WAIT: on sum_valid=1:
  - load res_data=sum_out, res_n=N;
  - → ACK.
  - Result register is always free here (IDLE guard).
- WAIT: counter reaches TIMEOUT-1 without sum_valid → load res_data=0, res_n=N, res_timeout=1; → IDLE. No ack is issued.
- ACK: ack=1 for one cycle; → IDLE.
- IDLE's sum_valid-low guard keeps a late or stale result from being taken as the next answer.
- Arithmetic: sum_out is passed through unchanged. For N_W=3 the maximum is 140, which fits 8 bits.
- N holds its last issued value outside ISSUE.

## Timing
- Reset (async assert, sync release): FIFO empty, state IDLE. All outputs 0 except req_ready=1.
- Reset mid-transaction: the in-flight request is dropped and no ack is sent.
- Request-to-issue latency, FIFO empty and IDLE:
  - push at edge k;
  - state ISSUE after edge k+1, so N_valid is high during the cycle after edge k+1;
  - WAIT after edge k+2.
- sum_valid sampled high at edge m (in WAIT): res_valid=1 and ack=1 after edge m. ack drops after edge m+1.
- N=0 request: res_valid rises after the edge following the push.
- Back-to-back: the next issue needs IDLE with sum_valid low. The minimum spacing between N_valid strobes is 4 cycles plus compute latency.
- Simultaneous push and pop: both occur; count unchanged.
- Full FIFO with simultaneous pop: push refused that cycle.
- res_ready low: the FSM waits in IDLE and the FIFO keeps accepting until full.

## Configuration
- SOS_CHECK_EN defined:
  - on WAIT capture, compare sum_out against N(N+1)(2N+1)/6, computed with ≥10-bit intermediates;
  - res_err=1 on mismatch;
  - the value is still passed through;
  - a timeout never sets res_err.
- SOS_CHECK_EN undefined: res_err tied 0 and no checker logic.

## Test plan
- Push N=4, compute model answers 30 after 5 cycles → one N_valid pulse with N=4. Then ack pulse, res_n=4, res_data=30, res_valid held until res_ready.
- Push 3, 7, 0, 1 back-to-back with res_ready=1 → results in order 14, 140, 0, 1. No N_valid is issued for N=0.
- res_ready=0, push 6 requests → req_ready drops once DEPTH entries are held and the first result is stalled. Releasing res_ready drains all in order, with no lost or duplicated results.
- Compute model never asserts sum_valid → res_valid with res_timeout=1 and res_data=0 after TIMEOUT cycles in WAIT. No ack; the next request is then serviced normally.
- Model returns 31 for N=4 → res_err=1 with SOS_CHECK_EN, 0 without; res_data=31 in both builds.
- Rst asserted low during WAIT → all outputs 0 immediately and FIFO empty. After release, a new N=2 request yields 5.
